// File: rtl/qs_pkg.sv
// qs_pkg: shared bank types, sizing and transition rules for the quicksort bank scheduler
package qs_pkg;
  localparam int BANK_N = 2;
  localparam int N = 64;
  localparam int BANK_ID_W = (BANK_N > 1) ? $clog2(BANK_N) : 1;
  localparam int N_W = $clog2(N + 1);
  typedef logic [BANK_ID_W-1:0] bank_id_t;
  typedef enum logic [2:0] {
    BANK_IDLE, BANK_LOADING, BANK_READY, BANK_SORTING, BANK_SORTED, BANK_UNLOADING
  } bank_status_t;
  typedef struct packed {
    logic err;
    logic [N_W-1:0] n;
    bank_status_t status;
  } bank_state_t;
  function automatic bank_id_t bank_id_inc(input bank_id_t i);
    return (BANK_N == 1) ? '0 : bank_id_t'(i + 1'b1);
  endfunction
  function automatic logic bank_trans_ok(input bank_status_t cur, input bank_status_t nxt);
    return (cur == BANK_IDLE && nxt == BANK_LOADING) ||
           (cur == BANK_LOADING && (nxt == BANK_LOADING || nxt == BANK_READY)) ||
           (cur == BANK_READY && nxt == BANK_SORTING) ||
           (cur == BANK_SORTING && nxt == BANK_SORTED) ||
           (cur == BANK_SORTED && nxt == BANK_UNLOADING) ||
           (cur == BANK_UNLOADING && (nxt == BANK_UNLOADING || nxt == BANK_IDLE));
  endfunction
endpackage

// File: rtl/qs_bnk_sched_srt.sv
// qs_bnk_sched_srt: sorter offer FSM and sort pointer; ports: clk, rst, bnk_status (status of bank at idx_r), start_rdy, done_vld, start_vld_r, busy, take, idx_r
module qs_bnk_sched_srt
  import qs_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  bank_status_t bnk_status,
  input  logic         start_rdy,
  input  logic         done_vld,
  output logic         start_vld_r,
  output logic         busy,
  output logic         take,
  output bank_id_t     idx_r
);
  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_BUSY} srt_state_t;
  srt_state_t state, state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx_r <= '0;
    end else begin
      state <= state_nxt;
      if (busy && done_vld) idx_r <= bank_id_inc(idx_r);
    end
  end
  // Leaving S_BUSY always lands in S_IDLE, so a new offer waits at least one cycle.
  always_comb begin
    start_vld_r = state == S_OFFER;
    busy = state == S_BUSY;
    take = start_vld_r && start_rdy;
    state_nxt = (state == S_IDLE && bnk_status == BANK_READY) ? S_OFFER :
                take ? S_BUSY :
                (busy && done_vld) ? S_IDLE : state;
  end
endmodule

// File: rtl/qs_bnk_sched.sv
// qs_bnk_sched: bank status table and round-robin enq/sort/deq scheduler
// Ports: clk, rst; enq_* (enqueue bank view and update), srt_* (sorter offer/done), deq_* (dequeue bank view and update), err_r (sticky error)
// Optional checker: define QS_BNK_SCHED_CHECK_EN to drop illegal updates and flag them in err_r.
module qs_bnk_sched
  import qs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output bank_id_t    enq_bnk_idx_r,
  output bank_state_t enq_bnk_r,
  input  logic        enq_upd_vld,
  input  bank_state_t enq_upd,
  output logic        srt_start_vld_r,
  input  logic        srt_start_rdy,
  output bank_id_t    srt_bnk_idx_r,
  output bank_state_t srt_bnk_r,
  input  logic        srt_done_vld,
  input  logic        srt_done_err,
  output bank_id_t    deq_bnk_idx_r,
  output bank_state_t deq_bnk_r,
  input  logic        deq_upd_vld,
  input  bank_state_t deq_upd,
  output logic        err_r
);
  bank_state_t tbl [BANK_N];
  bank_state_t srt_nxt;
  logic srt_busy, srt_take, srt_done, srt_w, srt_lose;
  logic enq_ok, enq_v, enq_lose, enq_w, deq_ok, deq_w;
  assign enq_bnk_r = tbl[enq_bnk_idx_r];
  assign srt_bnk_r = tbl[srt_bnk_idx_r];
  assign deq_bnk_r = tbl[deq_bnk_idx_r];
  qs_bnk_sched_srt u_srt (
    .clk        (clk),
    .rst        (rst),
    .bnk_status (srt_bnk_r.status),
    .start_rdy  (srt_start_rdy),
    .done_vld   (srt_done_vld),
    .start_vld_r(srt_start_vld_r),
    .busy       (srt_busy),
    .take       (srt_take),
    .idx_r      (srt_bnk_idx_r)
  );
  always_comb begin
    srt_done = srt_done_vld && srt_busy;
    srt_w = srt_take || srt_done;
    srt_nxt = srt_bnk_r;
    srt_nxt.status = srt_take ? BANK_SORTING : BANK_SORTED;
    srt_nxt.err = srt_bnk_r.err | (srt_done & srt_done_err);
`ifdef QS_BNK_SCHED_CHECK_EN
    enq_ok = bank_trans_ok(enq_bnk_r.status, enq_upd.status) &&
             (enq_upd.status inside {BANK_LOADING, BANK_READY});
    deq_ok = bank_trans_ok(deq_bnk_r.status, deq_upd.status) &&
             (deq_upd.status inside {BANK_UNLOADING, BANK_IDLE});
`else
    enq_ok = 1'b1;
    deq_ok = 1'b1;
`endif
    deq_w = deq_upd_vld && deq_ok;
    // Same-bank collisions resolve deq > srt > enq.
    srt_lose = srt_w && deq_w && srt_bnk_idx_r == deq_bnk_idx_r;
    enq_v = enq_upd_vld && enq_ok;
    enq_lose = enq_v && ((deq_w && enq_bnk_idx_r == deq_bnk_idx_r) ||
                         (srt_w && enq_bnk_idx_r == srt_bnk_idx_r));
    enq_w = enq_v && !enq_lose;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BANK_N; i++) tbl[i] <= '0;
      enq_bnk_idx_r <= '0;
      deq_bnk_idx_r <= '0;
    end else begin
      if (enq_w) tbl[enq_bnk_idx_r] <= enq_upd;
      if (srt_w && !srt_lose) tbl[srt_bnk_idx_r] <= srt_nxt;
      if (deq_w) tbl[deq_bnk_idx_r] <= deq_upd;
      if (enq_w && enq_upd.status == BANK_READY) enq_bnk_idx_r <= bank_id_inc(enq_bnk_idx_r);
      if (deq_w && deq_upd.status == BANK_IDLE) deq_bnk_idx_r <= bank_id_inc(deq_bnk_idx_r);
    end
  end
`ifdef QS_BNK_SCHED_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) err_r <= 1'b0;
    else err_r <= err_r | (enq_upd_vld & ~enq_ok) | (deq_upd_vld & ~deq_ok) |
                  srt_lose | enq_lose | (srt_done_vld & ~srt_busy);
  end
`else
  assign err_r = 1'b0;
`endif
endmodule

// File: tb/tb_qs_bnk_sched.sv
// tb_qs_bnk_sched: directed self-checking bench for qs_bnk_sched
module tb_qs_bnk_sched;
  import qs_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bank_id_t enq_bnk_idx_r, srt_bnk_idx_r, deq_bnk_idx_r;
  bank_state_t enq_bnk_r, srt_bnk_r, deq_bnk_r, enq_upd, deq_upd;
  logic enq_upd_vld = 1'b0, deq_upd_vld = 1'b0;
  logic srt_start_vld_r, srt_start_rdy = 1'b0, srt_done_vld = 1'b0, srt_done_err = 1'b0, err_r;
  int n_chk = 0;
  int n_pass = 0;

  qs_bnk_sched dut (
    .clk(clk), .rst(rst),
    .enq_bnk_idx_r(enq_bnk_idx_r), .enq_bnk_r(enq_bnk_r),
    .enq_upd_vld(enq_upd_vld), .enq_upd(enq_upd),
    .srt_start_vld_r(srt_start_vld_r), .srt_start_rdy(srt_start_rdy),
    .srt_bnk_idx_r(srt_bnk_idx_r), .srt_bnk_r(srt_bnk_r),
    .srt_done_vld(srt_done_vld), .srt_done_err(srt_done_err),
    .deq_bnk_idx_r(deq_bnk_idx_r), .deq_bnk_r(deq_bnk_r),
    .deq_upd_vld(deq_upd_vld), .deq_upd(deq_upd),
    .err_r(err_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bank_state_t bs(input int n, input bank_status_t s);
    bank_state_t v;
    v = '0;
    v.n = N_W'(n);
    v.status = s;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input bank_state_t v);
    enq_upd_vld = 1'b1;
    enq_upd = v;
    cyc();
    enq_upd_vld = 1'b0;
  endtask

  task automatic deq(input bank_state_t v);
    deq_upd_vld = 1'b1;
    deq_upd = v;
    cyc();
    deq_upd_vld = 1'b0;
  endtask

  initial begin
    enq_upd = '0;
    deq_upd = '0;
    cyc();
    cyc();
    check("rst_enq_idx", 32'(enq_bnk_idx_r), 0);
    check("rst_enq_bnk", 32'(enq_bnk_r), 0);
    check("rst_srt_idx", 32'(srt_bnk_idx_r), 0);
    check("rst_deq_idx", 32'(deq_bnk_idx_r), 0);
    check("rst_vld", 32'(srt_start_vld_r), 0);
    check("rst_err", 32'(err_r), 0);
    rst = 1'b0;
    enq(bs(0, BANK_LOADING));
    check("load_status", 32'(enq_bnk_r.status), 32'(BANK_LOADING));
    enq(bs(5, BANK_READY));
    check("enq_adv", 32'(enq_bnk_idx_r), 1);
    check("offer_early", 32'(srt_start_vld_r), 0);
    cyc();
    check("offer_vld", 32'(srt_start_vld_r), 1);
    check("offer_idx", 32'(srt_bnk_idx_r), 0);
    check("offer_n", 32'(srt_bnk_r.n), 5);
    cyc();
    check("offer_hold", 32'(srt_start_vld_r), 1);
    srt_start_rdy = 1'b1;
    cyc();
    srt_start_rdy = 1'b0;
    check("take_vld", 32'(srt_start_vld_r), 0);
    check("take_sorting", 32'(srt_bnk_r.status), 32'(BANK_SORTING));
    srt_done_vld = 1'b1;
    cyc();
    srt_done_vld = 1'b0;
    check("done_deq_sorted", 32'(deq_bnk_r.status), 32'(BANK_SORTED));
    check("done_deq_n", 32'(deq_bnk_r.n), 5);
    check("done_srt_idx", 32'(srt_bnk_idx_r), 1);
    deq(bs(5, BANK_UNLOADING));
    check("deq_unloading", 32'(deq_bnk_r.status), 32'(BANK_UNLOADING));
    deq(bs(0, BANK_IDLE));
    check("deq_adv", 32'(deq_bnk_idx_r), 1);
    check("flow_err", 32'(err_r), 0);
    // Back-to-back: bank 1 then bank 0 become READY while the sorter holds rdy low.
    enq(bs(3, BANK_LOADING));
    enq(bs(3, BANK_READY));
    check("wrap_enq_idx", 32'(enq_bnk_idx_r), 0);
    enq(bs(4, BANK_LOADING));
    enq(bs(4, BANK_READY));
    check("b2b_offer1", 32'(srt_start_vld_r), 1);
    check("b2b_idx1", 32'(srt_bnk_idx_r), 1);
    check("full_enq_idx", 32'(enq_bnk_idx_r), 1);
    check("full_enq_ready", 32'(enq_bnk_r.status), 32'(BANK_READY));
    srt_start_rdy = 1'b1;
    cyc();
    check("b2b_take1", 32'(srt_start_vld_r), 0);
    check("b2b_sorting1", 32'(srt_bnk_r.status), 32'(BANK_SORTING));
    cyc();
    check("b2b_busy", 32'(srt_start_vld_r), 0);
    srt_done_vld = 1'b1;
    cyc();
    srt_done_vld = 1'b0;
    check("b2b_gap", 32'(srt_start_vld_r), 0);
    check("b2b_idx0", 32'(srt_bnk_idx_r), 0);
    check("b2b_deq_sorted", 32'(deq_bnk_r.status), 32'(BANK_SORTED));
    cyc();
    check("b2b_offer0", 32'(srt_start_vld_r), 1);
    cyc();
    srt_start_rdy = 1'b0;
    check("b2b_take0", 32'(srt_start_vld_r), 0);
    check("b2b_sorting0", 32'(srt_bnk_r.status), 32'(BANK_SORTING));
    // Same cycle: deq starts unloading bank 1 while the sorter finishes bank 0 with an error.
    deq_upd_vld = 1'b1;
    deq_upd = bs(3, BANK_UNLOADING);
    srt_done_vld = 1'b1;
    srt_done_err = 1'b1;
    cyc();
    deq_upd_vld = 1'b0;
    srt_done_vld = 1'b0;
    srt_done_err = 1'b0;
    check("same_deq", 32'(deq_bnk_r.status), 32'(BANK_UNLOADING));
    check("same_srt_idx", 32'(srt_bnk_idx_r), 1);
    check("same_err", 32'(err_r), 0);
    check("full_enq_stall", 32'(enq_bnk_r.status == BANK_IDLE), 0);
    deq(bs(0, BANK_IDLE));
    check("full_release", 32'(enq_bnk_r.status), 32'(BANK_IDLE));
    check("release_deq_idx", 32'(deq_bnk_idx_r), 0);
    check("bank0_sorted", 32'(deq_bnk_r.status), 32'(BANK_SORTED));
    check("bank0_err", 32'(deq_bnk_r.err), 1);
    check("bank0_n", 32'(deq_bnk_r.n), 4);
    // Illegal IDLE->SORTED write from enqueue.
    enq(bs(7, BANK_SORTED));
    check("ill_enq_idx", 32'(enq_bnk_idx_r), 1);
`ifdef QS_BNK_SCHED_CHECK_EN
    check("ill_dropped", 32'(enq_bnk_r.status), 32'(BANK_IDLE));
    check("ill_err", 32'(err_r), 1);
    cyc();
    check("ill_err_sticky", 32'(err_r), 1);
`else
    check("ill_applied", 32'(enq_bnk_r.status), 32'(BANK_SORTED));
    check("ill_applied_n", 32'(enq_bnk_r.n), 7);
    check("ill_err", 32'(err_r), 0);
`endif
    srt_done_vld = 1'b1;
    cyc();
    srt_done_vld = 1'b0;
`ifdef QS_BNK_SCHED_CHECK_EN
    check("spurious_err", 32'(err_r), 1);
`else
    check("spurious_err", 32'(err_r), 0);
`endif
    check("spurious_srt_idx", 32'(srt_bnk_idx_r), 1);
    // Reset while an offer is pending.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    enq(bs(0, BANK_LOADING));
    enq(bs(2, BANK_READY));
    cyc();
    check("pre_rst_offer", 32'(srt_start_vld_r), 1);
    rst = 1'b1;
    cyc();
    check("mid_rst_vld", 32'(srt_start_vld_r), 0);
    check("mid_rst_enq_idx", 32'(enq_bnk_idx_r), 0);
    check("mid_rst_srt_idx", 32'(srt_bnk_idx_r), 0);
    check("mid_rst_deq_idx", 32'(deq_bnk_idx_r), 0);
    check("mid_rst_bnk", 32'(srt_bnk_r), 0);
    check("mid_rst_err", 32'(err_r), 0);
    rst = 1'b0;
    cyc();
    check("post_rst_vld", 32'(srt_start_vld_r), 0);
    check("post_rst_deq", 32'(deq_bnk_r), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
